// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared CPU fetch definitions: controller state encoding, instruction width, buffer entry layout.
package instr_fetch_ctrl_pkg;

  localparam int INSTR_W = 32;
  localparam int ENTRY_W = 2 * INSTR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
    return {addr[INSTR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_fetch_fifo.sv
// Fetch buffer: DEPTH-entry FIFO, head visible combinationally, pushed data visible one cycle later.
// Accepts a push when full only if the head pops the same cycle; flush empties it in one cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             core_clk,
  input  logic             arst_n,
  input  logic             flush,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign head_vld = (count != '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop_rdy && head_vld;
  assign do_push  = push_vld && (!full || do_pop);
  // Empty buffer presents zeros so the head never shows stale storage.
  assign head_dat = head_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (do_pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge core_clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: walks pc through a combinational imem into a small fetch buffer.
// First instruction visible 2 cycles after start; fetching stalls while the buffer is full and unpopped.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_WORDS  = 32,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               halt_i,
  input  logic               redirect_i,
  input  logic [INSTR_W-1:0] redirect_pc_i,
  output logic [INSTR_W-1:0] imem_addr_o,
  input  logic [INSTR_W-1:0] imem_instr_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [INSTR_W-1:0] instr_pc_o,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic               busy_o,
  output logic               err_o
);

  localparam logic [30:0] MEM_LIMIT = 31'(MEM_WORDS);

  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic               err_q, err_d;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_flush;
  logic               fifo_full;
  fetch_entry_t       push_entry;
  fetch_entry_t       head_entry;

  assign push_entry.pc    = pc_q;
  assign push_entry.instr = imem_instr_i;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fetch_fifo (
    .core_clk (clk_i),
    .arst_n   (rst_i),
    .flush    (fifo_flush),
    .push_vld (fifo_push),
    .push_dat (push_entry),
    .pop_rdy  (fifo_pop),
    .head_vld (instr_valid_o),
    .head_dat (head_entry),
    .full     (fifo_full)
  );

  assign imem_addr_o = pc_q;
  assign instr_o     = head_entry.instr;
  assign instr_pc_o  = head_entry.pc;
  assign busy_o      = (state_q == ST_RUN);
  assign err_o       = err_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    err_d      = err_q;
    fifo_push  = 1'b0;
    fifo_pop   = instr_valid_o && instr_ready_i;
    fifo_flush = 1'b0;

    if (redirect_i) begin
      // Redirect wins over everything and freezes the buffer for this cycle.
      fifo_flush = 1'b1;
      fifo_pop   = 1'b0;
      pc_d       = word_align(redirect_pc_i);
      state_d    = ST_IDLE;
      if (state_q == ST_ERR) err_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!halt_i && start_i) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (halt_i) begin
            state_d = ST_IDLE;
          end else if ({1'b0, pc_q[31:2]} >= MEM_LIMIT) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else if (!fifo_full || fifo_pop) begin
            fifo_push = 1'b1;
            pc_d      = pc_q + 32'd4;
          end
        end
        ST_ERR: begin
          state_d = ST_ERR;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded at reset.
REQ-002 SHALL have parameter MEM_WORDS, default 32, number of valid instruction words.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, fetch buffer entries (power of two, >=2).
REQ-004 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_i  input  1  pulse: begin/resume fetching.
REQ-007 SHALL have port halt_i  input  1  pulse: stop fetching, keep buffer.
REQ-008 SHALL have port redirect_i  input  1  branch/jump: flush and reload PC.
REQ-009 SHALL have port redirect_pc_i  input  32  redirect target byte address.
REQ-010 SHALL have port imem_addr_o  output  32  byte address to instruction memory (combinational read).
REQ-011 SHALL have port imem_instr_i  input  32  instruction word returned same cycle.
REQ-012 SHALL have port instr_o  output  32  buffer-head instruction.
REQ-013 SHALL have port instr_pc_o  output  32  byte address of instr_o.
REQ-014 SHALL have port instr_valid_o  output  1  buffer non-empty.
REQ-015 SHALL have port instr_ready_i  input  1  consumer accepts head this cycle.
REQ-016 SHALL have port busy_o  output  1  state is RUN.
REQ-017 SHALL have port err_o  output  1  sticky out-of-range fetch flag.

Function
REQ-018 SHALL implement states IDLE, RUN, ERR; reset state IDLE.
REQ-019 SHALL drive imem_addr_o = pc register at all times.
REQ-020 SHALL, in RUN, push {pc, imem_instr_i} and set pc <= pc+4 when buffer not full, or full with pop this cycle.
REQ-021 SHALL pop head when instr_valid_o && instr_ready_i; push and pop in one cycle keep count unchanged.
REQ-022 SHALL hold instr_o/instr_pc_o stable while instr_valid_o && !instr_ready_i.
REQ-023 SHALL transition IDLE->RUN on start_i; first push at end of that RUN cycle; instr_valid_o high 2 cycles after start_i sampled.
REQ-024 SHALL transition RUN->IDLE on halt_i with no push that cycle; buffer stays drainable.
REQ-025 SHALL, on redirect_i in any state, empty the buffer, set pc <= {redirect_pc_i[31:2],2'b00}, suppress push and pop that cycle.
REQ-026 SHALL leave state RUN on redirect in RUN; go ERR->IDLE and clear err_o on redirect in ERR; stay IDLE on redirect in IDLE.
REQ-027 SHALL, in RUN, when pc[31:2] >= MEM_WORDS, not push, set err_o, enter ERR; pc unchanged.
REQ-028 SHALL ignore start_i and halt_i in ERR.
REQ-029 SHALL prioritise redirect_i > halt_i > start_i when asserted together.
REQ-030 SHALL wrap pc modulo 2^32 on increment (range check then catches it).
REQ-031 SHALL wrap buffer read/write pointers modulo FIFO_DEPTH; no overflow or underflow ever occurs.

Reset
REQ-032 SHALL, on rst_i low, immediately set pc=RESET_PC, state IDLE, buffer empty, instr_valid_o=0, busy_o=0, err_o=0, instr_o=0, instr_pc_o=0.
REQ-033 SHALL discard any in-flight fetch on reset mid-operation; first post-reset fetch requires start_i.

Structure
REQ-034 SHALL place state encoding (IDLE/RUN/ERR) and instruction width constant 32 in the shared CPU package.
REQ-035 SHALL implement the buffer as sub-module fetch_fifo (parameterised depth, data width 64, flush input).

Verification
REQ-036 SHALL test: reset, start_i, instr_ready_i=1 -> instr_pc_o sequence 0x0,0x4,0x8 on consecutive cycles, instruction words match memory.
REQ-037 SHALL test: instr_ready_i=0 after start -> exactly 2 entries (pc 0x0,0x4), pc holds 0x8, head stable; ready=1 resumes without loss.
REQ-038 SHALL test: redirect_i with redirect_pc_i=0x41 while buffer full -> buffer empty next cycle, next instr_pc_o=0x40.
REQ-039 SHALL test: redirect to 0x78 with MEM_WORDS=32 -> fetches 0x78,0x7C, then err_o=1, state ERR, no further pushes; redirect to 0x0 clears err_o, IDLE.
REQ-040 SHALL test: redirect_i, halt_i, start_i same cycle in IDLE -> pc=target, state IDLE; halt_i in RUN -> busy_o=0, buffer drains.
REQ-041 SHALL test: rst_i low mid-run between clock edges -> outputs at reset values before next edge.
